// File: rtl/nec_pkg.sv
// NEC IR protocol shared definitions: transmitter state encoding, timing in
// 562.5 us ticks, and the 32-bit frame builder. The receiver side uses the
// same tick constants so both ends agree on the waveform.
package nec_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEAD_MARK,
    LEAD_SPACE,
    BIT_MARK,
    BIT_SPACE,
    STOP_MARK,
    GAP
  } nec_tx_state_t;

  // All durations in 562.5 us ticks.
  localparam int LEAD_MARK_T  = 16;
  localparam int LEAD_SPACE_T = 8;
  localparam int REP_SPACE_T  = 4;
  localparam int BIT_T        = 1;
  localparam int ONE_SPACE_T  = 3;
  localparam int PERIOD_T     = 192;  // 108 ms frame/repeat period

  // Transmission order is LSB first: addr, ~addr, cmd, ~cmd.
  function automatic logic [31:0] nec_frame(input logic [7:0] addr,
                                            input logic [7:0] cmd);
    return {~cmd, cmd, ~addr, addr};
  endfunction

  function automatic logic is_mark(input nec_tx_state_t s);
    return (s == LEAD_MARK) || (s == BIT_MARK) || (s == STOP_MARK);
  endfunction

endpackage

// File: rtl/nec_carrier_gen.sv
// IR carrier divider. Toggles phase every HALF clocks. sync restarts the
// carrier high so every mark begins on a rising carrier edge.
// Ports: clk, reset_n (async, active low), sync (restart), phase (carrier).
module nec_carrier_gen #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int CARRIER_HZ = 38_000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic sync,
  output logic phase
);

  // Clamp so a clock slower than twice the carrier still yields a legal divider.
  localparam int HALF_RAW = CLK_HZ / (2 * CARRIER_HZ);
  localparam int HALF     = (HALF_RAW < 1) ? 1 : HALF_RAW;
  localparam int CW       = (HALF > 1) ? $clog2(HALF) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (sync) begin
      cnt   <= '0;
      phase <= 1'b1;
    end else if (cnt == CW'(HALF - 1)) begin
      cnt   <= '0;
      phase <= ~phase;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/nec_ir_transmitter.sv
// NEC IR transmitter. On start, sends leader, 32 data bits LSB first and a
// stop mark inside a 108 ms period; while repeat_en is held at each period
// boundary, follows with repeat codes. done pulses once after the last period.
// Ports: clk, reset_n (async, active low), start, repeat_en, address[7:0],
//        command[7:0] in; busy, done, ir_env (mark envelope), ir_out (LED) out.
module nec_ir_transmitter
  import nec_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int CARRIER_HZ = 38_000,
  parameter bit MODULATE   = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       repeat_en,
  input  logic [7:0] address,
  input  logic [7:0] command,
  output logic       busy,
  output logic       done,
  output logic       ir_env,
  output logic       ir_out
);

  // Clocks per 562.5 us tick; 64-bit math keeps fast clocks from overflowing.
  localparam longint TICK_L = 64'(CLK_HZ) * 9 / 16000;
  localparam int     TICK   = int'(TICK_L);
  localparam int     TW     = (TICK > 1) ? $clog2(TICK) : 1;

  nec_tx_state_t state, nstate;
  logic [TW-1:0] cyc;          // clocks within current tick
  logic [4:0]    st_ticks;     // ticks spent in current state
  logic [4:0]    dur;          // required ticks for current state
  logic [4:0]    bit_cnt;
  logic [7:0]    frame_ticks;  // ticks since period start
  logic [31:0]   shift;
  logic          rep;
  logic          tick_end;
  logic          st_done;
  logic          sync;
  logic          phase;

  assign tick_end = (state != IDLE) && (cyc == TW'(TICK - 1));

  always_comb begin
    dur = 5'(BIT_T);
    case (state)
      LEAD_MARK:  dur = 5'(LEAD_MARK_T);
      LEAD_SPACE: dur = rep ? 5'(REP_SPACE_T) : 5'(LEAD_SPACE_T);
      BIT_SPACE:  dur = shift[0] ? 5'(ONE_SPACE_T) : 5'(BIT_T);
      default:    dur = 5'(BIT_T);
    endcase
    st_done = tick_end && (st_ticks == dur - 5'd1);

    nstate = state;
    case (state)
      IDLE:       if (start)   nstate = LEAD_MARK;
      LEAD_MARK:  if (st_done) nstate = LEAD_SPACE;
      LEAD_SPACE: if (st_done) nstate = rep ? STOP_MARK : BIT_MARK;
      BIT_MARK:   if (st_done) nstate = BIT_SPACE;
      BIT_SPACE:  if (st_done) nstate = (bit_cnt == 5'd31) ? STOP_MARK : BIT_MARK;
      STOP_MARK:  if (st_done) nstate = GAP;
      // GAP pads to a fixed period, so only the period counter matters here.
      GAP: if (tick_end && frame_ticks == 8'(PERIOD_T - 1))
             nstate = repeat_en ? LEAD_MARK : IDLE;
      default:    nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      cyc         <= '0;
      st_ticks    <= '0;
      frame_ticks <= '0;
      bit_cnt     <= '0;
      shift       <= '0;
      rep         <= 1'b0;
      done        <= 1'b0;
    end else begin
      state <= nstate;
      done  <= (state == GAP) && (nstate == IDLE);

      if (nstate != state || tick_end || state == IDLE) cyc <= '0;
      else                                              cyc <= cyc + 1'b1;

      if (nstate != state) st_ticks <= '0;
      else if (tick_end)   st_ticks <= st_ticks + 1'b1;

      // Every period (frame or repeat) starts on LEAD_MARK entry.
      if (nstate == LEAD_MARK && state != LEAD_MARK) frame_ticks <= '0;
      else if (tick_end)                             frame_ticks <= frame_ticks + 1'b1;

      if (state == IDLE && start) begin
        shift   <= nec_frame(address, command);
        rep     <= 1'b0;
        bit_cnt <= '0;
      end else if (state == GAP && nstate == LEAD_MARK) begin
        rep <= 1'b1;
      end else if (state == BIT_SPACE && st_done) begin
        shift   <= shift >> 1;
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

  assign sync = is_mark(nstate) && (nstate != state);

  nec_carrier_gen #(
    .CLK_HZ    (CLK_HZ),
    .CARRIER_HZ(CARRIER_HZ)
  ) u_carrier (
    .clk    (clk),
    .reset_n(reset_n),
    .sync   (sync),
    .phase  (phase)
  );

  assign busy   = (state != IDLE);
  assign ir_env = is_mark(state);
  assign ir_out = MODULATE ? (ir_env & phase) : ir_env;

endmodule

// File: tb/tb_nec_ir_transmitter.sv
// Scoreboard bench for nec_ir_transmitter. Stimulus pushes the expected
// envelope segments, busy length and decoded word; a negedge monitor measures
// the DUT waveform and pops/compares as segments close and done fires.
module tb_nec_ir_transmitter;

  localparam int CLK_HZ = 16000;
  localparam int CAR_HZ = 2000;
  localparam int T      = CLK_HZ * 9 / 16000;       // 9 clocks per tick
  localparam int HALF   = CLK_HZ / (2 * CAR_HZ);    // 4
  localparam int PER    = 192 * T;                  // 1728 clocks per period

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic       repeat_en = 1'b0;
  logic [7:0] address = '0;
  logic [7:0] command = '0;
  logic       busy, done, ir_env, ir_out;

  nec_ir_transmitter #(
    .CLK_HZ(CLK_HZ), .CARRIER_HZ(CAR_HZ), .MODULATE(1'b1)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .repeat_en(repeat_en),
    .address(address), .command(command),
    .busy(busy), .done(done), .ir_env(ir_env), .ir_out(ir_out)
  );

  always #5 clk = ~clk;

  typedef struct { bit lvl; int len; } seg_t;
  seg_t        exp_seg[$];
  int          exp_busy[$];
  logic [31:0] exp_word[$];

  int n_cmp = 0, n_bad = 0;
  int n_done = 0, n_done_exp = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference waveform built from the protocol rules: a list of mark/space
  // run lengths, with each period padded to 192 ticks before the next one.
  task automatic push_model(input logic [7:0] a, input logic [7:0] c, input int nrep);
    logic [31:0] w;
    int act;
    w = {~c, c, ~a, a};
    exp_seg.push_back('{1'b1, 16 * T});
    exp_seg.push_back('{1'b0, 8 * T});
    act = 24;
    for (int i = 0; i < 32; i++) begin
      exp_seg.push_back('{1'b1, T});
      exp_seg.push_back('{1'b0, w[i] ? 3 * T : T});
      act += w[i] ? 4 : 2;
    end
    exp_seg.push_back('{1'b1, T});
    act += 1;
    for (int r = 0; r < nrep; r++) begin
      exp_seg.push_back('{1'b0, (192 - act) * T});
      exp_seg.push_back('{1'b1, 16 * T});
      exp_seg.push_back('{1'b0, 4 * T});
      exp_seg.push_back('{1'b1, T});
      act = 21;
    end
    exp_word.push_back(w);
    exp_busy.push_back(PER * (nrep + 1));
  endtask

  // ---------------- monitor ----------------
  logic        prev_env = 1'b0;
  int          seg_len = 0;
  bit          skip_space = 1'b1;  // idle/trailing gap spaces are unbounded
  bit          carrier_bad = 1'b0;
  bit          collecting = 1'b0;
  int          nbits = 0;
  int          last_mark = 0;
  int          busy_cnt = 0;
  logic [31:0] got_word = '0;

  task automatic pop_cmp(input bit lvl, input int len);
    seg_t s;
    if (exp_seg.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL seg_unexpected: got level %0d len %0d expected none", lvl, len);
    end else begin
      s = exp_seg.pop_front();
      check("seg_level", lvl, s.lvl);
      check(lvl ? "mark_len" : "space_len", len, s.len);
    end
  endtask

  task automatic close_segment(input bit lvl, input int len);
    if (lvl) begin
      pop_cmp(1'b1, len);
      check("carrier", carrier_bad, 0);
      carrier_bad = 1'b0;
      last_mark = len;
    end else begin
      if (!skip_space) begin
        pop_cmp(1'b0, len);
        if (last_mark == 16 * T && len == 8 * T) begin
          collecting = 1'b1;
          nbits = 0;
        end else if (collecting) begin
          got_word[nbits] = (len > 2 * T);
          nbits++;
          if (nbits == 32) begin
            collecting = 1'b0;
            if (exp_word.size() == 0) begin
              n_cmp++; n_bad++;
              $display("FAIL word_unexpected: got 0x%0h expected none", got_word);
            end else check("frame_word", got_word, exp_word.pop_front());
          end
        end
      end
      skip_space = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    if (!reset_n) begin
      prev_env = 1'b0; seg_len = 0; skip_space = 1'b1; carrier_bad = 1'b0;
      collecting = 1'b0; last_mark = 0; busy_cnt = 0;
    end else begin
      if (ir_env !== prev_env) begin
        close_segment(prev_env, seg_len);
        prev_env = ir_env;
        seg_len = 1;
      end else seg_len++;
      // Carrier: high for the first HALF clocks of every mark, then alternating.
      if (ir_env) begin
        if (ir_out !== ((((seg_len - 1) / HALF) % 2) == 0)) carrier_bad = 1'b1;
      end else if (ir_out !== 1'b0) carrier_bad = 1'b1;
      if (busy) busy_cnt++;
      if (done) begin
        n_done++;
        check("busy_low_at_done", busy, 0);
        if (exp_busy.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL done_unexpected: got done after %0d busy cycles expected none", busy_cnt);
        end else check("busy_len", busy_cnt, exp_busy.pop_front());
        busy_cnt = 0;
        skip_space = 1'b1;
      end
    end
  end

  // ---------------- driver ----------------
  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] c, input int nrep, input bit spur);
    int d0, k, limit;
    push_model(a, c, nrep);
    n_done_exp++;
    tick();
    address = a; command = c; start = 1'b1; repeat_en = (nrep > 0);
    tick();
    start = 1'b0;
    check("busy_rise", busy, 1);
    check("env_rise", ir_env, 1);
    d0 = n_done; k = 1; limit = PER * (nrep + 1) + 50;
    while (n_done == d0 && k < limit) begin
      tick(); k++;
      if (k == 500 && spur) begin start = 1'b1; address = ~a; end
      if (k == 501) start = 1'b0;
      if (k == 700) begin address = 8'($urandom); command = 8'($urandom); end
      if (k == PER * nrep + 600) repeat_en = 1'b0;
    end
    check("done_seen", n_done, d0 + 1);
    start = 1'b0; repeat_en = 1'b0;
    repeat (20) tick();
    check("idle_after_done", busy, 0);
  endtask

  task automatic abort_frame(input logic [7:0] a, input logic [7:0] c);
    int k;
    push_model(a, c, 0);
    tick();
    address = a; command = c; start = 1'b1;
    tick();
    start = 1'b0;
    k = 0;
    while (!(ir_env && k > 250) && k < 1000) begin tick(); k++; end
    check("abort_in_mark", ir_env, 1);
    #2 reset_n = 1'b0;
    #1;
    check("rst_ir_env", ir_env, 0);
    check("rst_ir_out", ir_out, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    exp_seg.delete(); exp_busy.delete(); exp_word.delete();
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (5) tick();
    check("post_rst_busy", busy, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) tick();
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_env", ir_env, 0);
    check("reset_out", ir_out, 0);
    reset_n = 1'b1;
    repeat (3) tick();

    send(8'h00, 8'h00, 0, 1'b0);
    send(8'h59, 8'h16, 0, 1'b0);
    send(8'($urandom), 8'($urandom), 2, 1'b0);
    send(8'($urandom), 8'($urandom), 0, 1'b1);
    abort_frame(8'($urandom), 8'($urandom));
    send(8'h59, 8'h16, 0, 1'b0);
    for (int i = 0; i < 6; i++)
      send(8'($urandom), 8'($urandom), int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

    repeat (50) tick();
    check("seg_queue_empty", exp_seg.size(), 0);
    check("busy_queue_empty", exp_busy.size(), 0);
    check("word_queue_empty", exp_word.size(), 0);
    check("done_count", n_done, n_done_exp);
    check("final_idle", busy, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
